// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings for the in-order RV32 core pipeline stages
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } mem_state_e;

    // Bytes are always aligned; halves need addr[0]=0; anything wider needs a word boundary.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~addr_lo[0];
            default:     ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_be.sv
// rtl/dmem_be.sv - word-organised data RAM with per-byte write enables and combinational read
module dmem_be #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage_pl.sv
// rtl/mem_wb_stage_pl.sv - RV32 memory-access stage with latency FSM and MEM/WB pipeline register
module mem_wb_stage_pl
    import core_pkg::*;
#(
    parameter int XLEN       = core_pkg::XLEN,
    parameter int DEPTH_LOG2 = 10,
    parameter int MEM_LAT    = 0,
    parameter int RA_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            valid_m,
    input  logic            reg_write_m,
    input  logic [1:0]      result_src_m,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic [2:0]      funct3_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] write_data_m,
    input  logic [XLEN-1:0] pc_plus4_m,
    input  logic [RA_W-1:0] rd_m,
    output logic            stall_m_o,
    output logic            misalign_o,
    output logic            valid_w,
    output logic            reg_write_w,
    output logic [RA_W-1:0] rd_w,
    output logic [XLEN-1:0] alu_result_w,
    output logic [XLEN-1:0] read_data_w,
    output logic [XLEN-1:0] pc_plus4_w,
    output logic [XLEN-1:0] result_w
);

    localparam logic [3:0] LAT_M1 = 4'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);

    mem_state_e      state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic            stall, complete;
    logic [1:0]      addr_lo;
    logic            aligned, mem_op, acc, misalign;
    logic [3:0]      be;
    logic [31:0]     wdata_rep, rdata, shifted, load_data;
    logic [1:0]      result_src_w;
    logic            unused_addr;

    assign addr_lo  = alu_result_m[1:0];
    assign aligned  = is_aligned(funct3_m, addr_lo);
    assign mem_op   = valid_m & (mem_read_m | mem_write_m) & ~flush_i;
    assign acc      = mem_op & aligned;
    assign misalign = mem_op & ~aligned;

    // Upper address bits fold onto the RAM, so accesses alias by design.
    assign unused_addr = ^alu_result_m[XLEN-1:DEPTH_LOG2+2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // A flush drops acc, which both cancels the pending commit and releases the stall.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        stall    = 1'b0;
        complete = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    if (MEM_LAT == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_n = S_BUSY;
                        cnt_n   = LAT_M1;
                    end
                end
            end
            S_BUSY: begin
                if (!acc) begin
                    state_n = S_IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt == 4'd0) begin
                    complete = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    assign stall_m_o = stall;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = write_data_m[31:0];
        case (funct3_m)
            F3_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{write_data_m[7:0]}};
            end
            F3_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{write_data_m[15:0]}};
            end
            F3_W: begin
                be        = 4'b1111;
                wdata_rep = write_data_m[31:0];
            end
            default: be = 4'b0000;
        endcase
    end

    dmem_be #(
        .AW(DEPTH_LOG2)
    ) u_dmem (
        .clk   (clk),
        .addr  (alu_result_m[DEPTH_LOG2+1:2]),
        .we    (complete & mem_write_m),
        .be    (be),
        .wdata (wdata_rep),
        .rdata (rdata)
    );

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = rdata;
        case (funct3_m)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_o   <= 1'b0;
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            rd_w         <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
            pc_plus4_w   <= '0;
            result_src_w <= RES_ALU;
        end else begin
            misalign_o <= misalign;
            if (flush_i || stall) begin
                valid_w     <= 1'b0;
                reg_write_w <= 1'b0;
            end else begin
                valid_w      <= valid_m;
                reg_write_w  <= valid_m & reg_write_m & ~misalign;
                rd_w         <= rd_m;
                alu_result_w <= alu_result_m;
                read_data_w  <= XLEN'(load_data);
                pc_plus4_w   <= pc_plus4_m;
                result_src_w <= result_src_m;
            end
        end
    end

    always_comb begin
        case (result_src_w)
            RES_MEM: result_w = read_data_w;
            RES_PC4: result_w = pc_plus4_w;
            default: result_w = alu_result_w;
        endcase
    end

endmodule

// File: doc/mem_wb_stage_pl.md
Name: mem_wb_stage_pl

Overview:
- Parametrised memory-access stage plus MEM/WB pipeline register for the in-order RISC-V core.
- Contains a byte-addressable data RAM with RV32 load/store sizing (B/H/W, signed/unsigned) and misalignment detection.
- Supports a configurable memory latency; a small FSM stalls the upstream pipe while an access is outstanding.
- Drives a pre-muxed writeback result to the register file and forwarding paths.

Parameters:
- XLEN, 32, datapath width; must be 32.
- DEPTH_LOG2, 10, RAM depth of 2^DEPTH_LOG2 words; indexed by alu_result_m[DEPTH_LOG2+1:2].
- MEM_LAT, 0, extra wait cycles per load/store; range 0..15.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- flush_i  in  1  kill the instruction currently in M.
- valid_m  in  1  M holds a real instruction.
- reg_write_m  in  1  instruction writes rd.
- result_src_m  in  2  writeback source: 00 ALU, 01 memory, 10 PC+4, 11 reserved (selects ALU).
- mem_read_m  in  1  load.
- mem_write_m  in  1  store.
- funct3_m  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_result_m  in  XLEN  address or ALU result.
- write_data_m  in  XLEN  store data, right-aligned.
- pc_plus4_m  in  XLEN  PC+4.
- rd_m  in  RA_W  destination register.
- stall_m_o  out  1  hold F/D/E/M stages.
- misalign_o  out  1  one-cycle pulse on a misaligned access.
- valid_w  out  1  W holds a real instruction.
- reg_write_w  out  1  register-file write enable.
- rd_w  out  RA_W  destination register.
- alu_result_w, read_data_w, pc_plus4_w  out  XLEN  registered copies.
- result_w  out  XLEN  selected writeback value.

Behaviour:
- Reset: all W outputs 0, stall_m_o 0, misalign_o 0, FSM IDLE, counter 0. RAM contents are not reset.
- Access is defined as acc = valid_m & (mem_read_m | mem_write_m) & aligned & !flush_i.
- Alignment rules:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=00.
  - B is always aligned.
- FSM states:
  - IDLE: if acc and MEM_LAT>0, go to BUSY with cnt=MEM_LAT-1; stall_m_o=1 combinationally in that same cycle.
  - BUSY: stall_m_o=1 while cnt!=0; cnt decrements each cycle. When cnt==0, stall_m_o=0, the access completes, and the FSM returns to IDLE.
  - MEM_LAT=0: the FSM stays in IDLE; every access completes in its first M cycle. An access therefore occupies M for MEM_LAT+1 cycles.
- Store commit:
  - The RAM write happens only on the completing cycle, exactly once.
  - Byte enables: SB uses 1 lane at addr[1:0]; SH uses 2 lanes at addr[1]; SW uses all 4 lanes.
  - write_data_m is replicated across lanes.
- Load read:
  - Combinational RAM read on the completing cycle.
  - The selected byte or half is shifted down, then sign-extended (B/H) or zero-extended (BU/HU).
- W register update (priority order):
  1. Reset.
  2. flush_i or stall_m_o: bubble (valid_w=0, reg_write_w=0, data fields hold).
  3. Otherwise: capture M fields.
- Misaligned access:
  - No RAM write and no stall.
  - misalign_o pulses for 1 cycle.
  - The instruction still advances with reg_write_w forced to 0.
- Flush during BUSY: FSM returns to IDLE immediately, the pending store is not committed, and W gets a bubble.
- valid_m=0: reg_write_w is forced to 0 in W.
- result_w is combinational from the W registers via result_src_w (internal register).
- Address bits above DEPTH_LOG2+1 are ignored, so accesses alias.

Decomposition:
- Shared package core_pkg:
  - RES_ALU/RES_MEM/RES_PC4 encodings.
  - F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - XLEN.
- Sub-module dmem_be: byte-enable RAM, 4 lanes × 8 bits, with synchronous write and combinational read.
- The FSM, lane formatting and pipeline register stay in the top module.

Test Plan:
- MEM_LAT=0: SW 0xDEADBEEF @0x10, then LW @0x10 → read_data_w=result_w=0xDEADBEEF one cycle later; stall_m_o never 1.
- After the above, LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; SB 0x55 @0x11 then LW → 0xDEAD55EF.
- MEM_LAT=2: LW → stall_m_o high for exactly 2 cycles, W bubbles (valid_w=0) during the stall, data lands in W on the 3rd cycle; a back-to-back SW produces exactly one RAM write.
- LW @0x12 → misalign_o 1 for 1 cycle, reg_write_w=0, RAM unchanged, no stall.
- MEM_LAT=3: SW then flush_i in the 2nd BUSY cycle → FSM to IDLE, stall_m_o drops, a subsequent LW returns the old data.
- Assert rst low mid-BUSY → all outputs 0 asynchronously, no commit; after release an ADD (result_src=00, rd=7, ALU=42) gives rd_w=7, result_w=42, reg_write_w=1.
